// File: rtl/pacman_move_if.sv
`default_nettype none
// ============================================================================
// Module      : pacman_move_if
// Description : Joystick / wall-check inputs and direction / motion outputs
//               of the Pac-Man movement scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface pacman_move_if;
    logic [11:0] x_val;
    logic [11:0] y_val;
    logic [3:0]  wall_free;
    logic        tile_aligned;
    logic        freeze;
    logic        respawn;
    logic [1:0]  dir;
    logic        moving;
    logic        step_en;
    logic [9:0]  motion_x;
    logic [9:0]  motion_y;
    logic        has_moved;
    logic        pend_valid;

    modport master (
        output x_val, y_val, wall_free, tile_aligned, freeze, respawn,
        input  dir, moving, step_en, motion_x, motion_y, has_moved, pend_valid
    );

    modport slave (
        input  x_val, y_val, wall_free, tile_aligned, freeze, respawn,
        output dir, moving, step_en, motion_x, motion_y, has_moved, pend_valid
    );
endinterface
`default_nettype wire

// File: rtl/pacman_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pacman_move_ctrl
// Description : Debounces joystick requests, buffers turns until legal and
//               paces one-pixel steps of the Pac-Man sprite.
// Revision    : 1.0 - initial release
// ============================================================================
module pacman_move_ctrl #(
    parameter int unsigned LO_TH       = 400,
    parameter int unsigned HI_TH       = 2300,
    parameter int unsigned DEBOUNCE    = 3,
    parameter int unsigned SPEED_DIV   = 2,
    parameter int unsigned HOLD_FRAMES = 16
) (
    input  wire              frame_clk,
    input  wire              Reset,
    pacman_move_if.slave     bus
);

    localparam logic [11:0] c_lo        = 12'(LO_TH);
    localparam logic [11:0] c_hi        = 12'(HI_TH);
    localparam logic [3:0]  c_db        = 4'(DEBOUNCE);
    localparam logic [3:0]  c_spd_last  = 4'(SPEED_DIV - 1);
    localparam logic [7:0]  c_hold_last = 8'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_STOP   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_dir;
    logic        r_moving;
    logic        r_step_en;
    logic [9:0]  r_motion_x;
    logic [9:0]  r_motion_y;
    logic        r_has_moved;
    logic        r_pend_valid;
    logic [1:0]  r_pend_dir;
    logic [7:0]  r_hold_cnt;
    logic [3:0]  r_spd_cnt;
    logic [1:0]  r_cand;
    logic [3:0]  r_db_cnt;

    logic        w_raw_valid;
    logic [1:0]  w_raw_dir;
    logic [1:0]  w_cand_nxt;
    logic [3:0]  w_db_cnt_nxt;
    logic        w_accept;
    logic        w_drop;
    logic        w_apply;
    logic        w_legal_ctx;

    // Motion vector for a moving sprite heading in direction d: {x, y}.
    function automatic logic [19:0] motion_of(input logic [1:0] d);
        logic [19:0] v;
        case (d)
            2'd0:    v = {10'd1,   10'd0};
            2'd1:    v = {10'd0,   10'd1};
            2'd2:    v = {10'h3FF, 10'd0};
            default: v = {10'd0,   10'h3FF};
        endcase
        return v;
    endfunction

    always_comb begin
        w_raw_valid = 1'b1;
        w_raw_dir   = 2'd0;
        if (bus.x_val <= c_lo) begin
            w_raw_dir = 2'd0;
        end else if (bus.x_val >= c_hi) begin
            w_raw_dir = 2'd2;
        end else if (bus.y_val >= c_hi) begin
            w_raw_dir = 2'd3;
        end else if (bus.y_val <= c_lo) begin
            w_raw_dir = 2'd1;
        end else begin
            w_raw_valid = 1'b0;
        end
    end

    // Acceptance fires only on the transition into DEBOUNCE, so a held stick
    // produces exactly one request.
    always_comb begin
        w_cand_nxt   = r_cand;
        w_db_cnt_nxt = r_db_cnt;
        w_accept     = 1'b0;
        if (!w_raw_valid) begin
            w_db_cnt_nxt = 4'd0;
        end else if (w_raw_dir != r_cand) begin
            w_cand_nxt   = w_raw_dir;
            w_db_cnt_nxt = 4'd1;
            w_accept     = (c_db == 4'd1);
        end else if (r_db_cnt != c_db) begin
            w_db_cnt_nxt = r_db_cnt + 4'd1;
            w_accept     = ((r_db_cnt + 4'd1) == c_db);
        end
    end

    always_comb begin
        w_drop      = r_pend_valid && (r_state == S_MOVE) && (r_pend_dir == r_dir);
        w_legal_ctx = 1'b0;
        case (r_state)
            S_MOVE:         w_legal_ctx = bus.tile_aligned || (r_pend_dir == (r_dir ^ 2'd2));
            S_IDLE, S_STOP: w_legal_ctx = 1'b1;
            default:        w_legal_ctx = 1'b0;
        endcase
        w_apply = r_pend_valid && !w_drop && bus.wall_free[r_pend_dir] && w_legal_ctx;
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_dir        <= 2'd0;
            r_moving     <= 1'b0;
            r_step_en    <= 1'b0;
            r_motion_x   <= 10'd0;
            r_motion_y   <= 10'd0;
            r_has_moved  <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= 2'd0;
            r_hold_cnt   <= 8'd0;
            r_spd_cnt    <= 4'd0;
            r_cand       <= 2'd0;
            r_db_cnt     <= 4'd0;
        end else if (bus.freeze || (r_state == S_FROZEN)) begin
            // Sticky until Reset; dir and has_moved keep their last values.
            r_state      <= S_FROZEN;
            r_moving     <= 1'b0;
            r_step_en    <= 1'b0;
            r_motion_x   <= 10'd0;
            r_motion_y   <= 10'd0;
            r_pend_valid <= 1'b0;
            r_hold_cnt   <= 8'd0;
            r_spd_cnt    <= 4'd0;
            r_cand       <= 2'd0;
            r_db_cnt     <= 4'd0;
        end else if (bus.respawn) begin
            r_state      <= S_IDLE;
            r_dir        <= 2'd0;
            r_moving     <= 1'b0;
            r_step_en    <= 1'b0;
            r_motion_x   <= 10'd0;
            r_motion_y   <= 10'd0;
            r_has_moved  <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= 2'd0;
            r_hold_cnt   <= 8'd0;
            r_spd_cnt    <= 4'd0;
            r_cand       <= 2'd0;
            r_db_cnt     <= 4'd0;
        end else begin
            r_cand    <= w_cand_nxt;
            r_db_cnt  <= w_db_cnt_nxt;
            r_step_en <= 1'b0;

            // A fresh acceptance supersedes whatever happened to the old request.
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_dir   <= w_raw_dir;
                r_hold_cnt   <= 8'd0;
            end else if (w_apply || w_drop || (r_pend_valid && (r_hold_cnt == c_hold_last))) begin
                r_pend_valid <= 1'b0;
                r_hold_cnt   <= 8'd0;
            end else if (r_pend_valid) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end

            if (w_apply) begin
                r_state                  <= S_MOVE;
                r_dir                    <= r_pend_dir;
                r_moving                 <= 1'b1;
                r_has_moved              <= 1'b1;
                r_spd_cnt                <= 4'd0;
                {r_motion_x, r_motion_y} <= motion_of(r_pend_dir);
            end else if (r_state == S_MOVE) begin
                if (!bus.wall_free[r_dir] && bus.tile_aligned) begin
                    r_state    <= S_STOP;
                    r_moving   <= 1'b0;
                    r_motion_x <= 10'd0;
                    r_motion_y <= 10'd0;
                    r_spd_cnt  <= 4'd0;
                end else begin
                    r_spd_cnt <= (r_spd_cnt == c_spd_last) ? 4'd0 : r_spd_cnt + 4'd1;
                    r_step_en <= (r_spd_cnt == c_spd_last) && bus.wall_free[r_dir];
                end
            end
        end
    end

    assign bus.dir        = r_dir;
    assign bus.moving     = r_moving;
    assign bus.step_en    = r_step_en;
    assign bus.motion_x   = r_motion_x;
    assign bus.motion_y   = r_motion_y;
    assign bus.has_moved  = r_has_moved;
    assign bus.pend_valid = r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_pacman_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pacman_move_ctrl
// Description : Scenario and randomized checks of pacman_move_ctrl against a
//               frame-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_move_ctrl;

    localparam int LO_TH       = 400;
    localparam int HI_TH       = 2300;
    localparam int DEBOUNCE    = 3;
    localparam int SPEED_DIV   = 2;
    localparam int HOLD_FRAMES = 16;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   n_vec     = 0;
    int   n_err     = 0;

    pacman_move_if bus ();

    pacman_move_ctrl #(
        .LO_TH(LO_TH), .HI_TH(HI_TH), .DEBOUNCE(DEBOUNCE),
        .SPEED_DIV(SPEED_DIV), .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 frame_clk = ~frame_clk;

    // Model: the sprite is either frozen, moving, or parked (spawn or wall).
    int m_dir, m_pdir, m_hold, m_run, m_last, m_age;
    bit m_moving, m_step, m_hm, m_pend, m_frozen;

    task automatic model_clear();
        m_dir = 0; m_pdir = 0; m_hold = 0; m_run = 0; m_last = -1; m_age = 0;
        m_moving = 0; m_step = 0; m_hm = 0; m_pend = 0;
    endtask

    task automatic model(input logic [11:0] xv, yv, input logic [3:0] wf,
                         input logic al, fr, rs, rst);
        int  r, new_run, old_run;
        bit  accept, drop, apply;
        r = -1;
        if (int'(xv) <= LO_TH)      r = 0;
        else if (int'(xv) >= HI_TH) r = 2;
        else if (int'(yv) >= HI_TH) r = 3;
        else if (int'(yv) <= LO_TH) r = 1;
        if (rst) begin
            model_clear();
            m_frozen = 0;
        end else if (m_frozen || fr) begin
            m_frozen = 1; m_moving = 0; m_step = 0; m_pend = 0; m_hold = 0;
            m_run = 0; m_last = -1;
        end else if (rs) begin
            model_clear();
        end else begin
            old_run = (r >= 0 && r == m_last) ? m_run : 0;
            if (r < 0)            new_run = 0;
            else if (r == m_last) new_run = (m_run < DEBOUNCE) ? m_run + 1 : m_run;
            else                  new_run = 1;
            accept = (r >= 0) && (new_run == DEBOUNCE) && (old_run != DEBOUNCE);
            m_run = new_run;
            if (r >= 0) m_last = r;

            drop  = m_pend && m_moving && (m_pdir == m_dir);
            apply = m_pend && !drop && wf[m_pdir] &&
                    (!m_moving || al || (m_pdir == ((m_dir + 2) % 4)));

            m_step = 0;
            if (apply) begin
                m_dir = m_pdir; m_hm = 1; m_moving = 1; m_age = 0;
            end else if (m_moving) begin
                if (!wf[m_dir] && al) begin
                    m_moving = 0;
                end else begin
                    m_step = ((m_age % SPEED_DIV) == SPEED_DIV - 1) && wf[m_dir];
                    m_age++;
                end
            end

            if (accept) begin
                m_pend = 1; m_pdir = r; m_hold = 0;
            end else if (apply || drop || (m_pend && m_hold == HOLD_FRAMES - 1)) begin
                m_pend = 0; m_hold = 0;
            end else if (m_pend) begin
                m_hold++;
            end
        end
    endtask

    function automatic logic [26:0] exp_vec();
        logic [9:0] mx, my;
        mx = 10'd0; my = 10'd0;
        if (m_moving) begin
            case (m_dir)
                0:       mx = 10'd1;
                1:       my = 10'd1;
                2:       mx = 10'h3FF;
                default: my = 10'h3FF;
            endcase
        end
        return {2'(m_dir), m_moving, m_step, mx, my, m_hm, m_pend};
    endfunction

    function automatic logic [26:0] got_vec();
        return {bus.dir, bus.moving, bus.step_en, bus.motion_x, bus.motion_y,
                bus.has_moved, bus.pend_valid};
    endfunction

    task automatic tick(input logic [11:0] xv, yv, input logic [3:0] wf,
                        input logic al, fr, rs, rst);
        bus.x_val = xv; bus.y_val = yv; bus.wall_free = wf;
        bus.tile_aligned = al; bus.freeze = fr; bus.respawn = rs; Reset = rst;
        @(posedge frame_clk);
        #1;
        model(xv, yv, wf, al, fr, rs, rst);
    endtask

    task automatic start_right();
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(12'd100, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(12'd2000, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(12'd2000, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (got_vec() !== 27'd0) begin
            n_err++;
            $display("FAIL reset_state got=%h exp=%h", got_vec(), 27'd0);
        end
    endtask

    task automatic test_idle_entry();
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(12'd100, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL idle_entry cyc=%0d got=%h exp=%h", i + 1, got_vec(), exp_vec());
            end
            if (i == 2) begin
                n_vec++;
                if (bus.pend_valid !== 1'b1 || bus.moving !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle_pend_c3 pend=%b mov=%b exp pend=1 mov=0", bus.pend_valid, bus.moving);
                end
            end
            if (i == 3) begin
                n_vec++;
                if ({bus.dir, bus.moving, bus.has_moved, bus.motion_x} !== {2'd0, 1'b1, 1'b1, 10'd1}) begin
                    n_err++;
                    $display("FAIL idle_move_c4 dir=%0d mov=%b hm=%b mx=%h exp 0 1 1 001",
                             bus.dir, bus.moving, bus.has_moved, bus.motion_x);
                end
            end
            if (i >= 3) begin
                n_vec++;
                if (bus.step_en !== ((i % 2) == 1 && i >= 5)) begin
                    n_err++;
                    $display("FAIL idle_step_c%0d got=%b exp=%b", i + 1, bus.step_en, (i % 2) == 1 && i >= 5);
                end
            end
        end
    endtask

    task automatic test_glitch();
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick((i < 2) ? 12'd3000 : 12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (bus.pend_valid !== 1'b0 || bus.dir !== 2'd0 || got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL glitch cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_turn_buffered();
        start_right();
        for (int i = 0; i < 3; i++) tick(12'd2000, 12'd2500, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(12'd2000, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (bus.pend_valid !== 1'b1 || bus.dir !== 2'd0 || got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL turn_wait cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus.dir, bus.motion_y, bus.motion_x, bus.pend_valid} !== {2'd3, 10'h3FF, 10'd0, 1'b0}) begin
            n_err++;
            $display("FAIL turn_apply dir=%0d my=%h mx=%h pend=%b exp 3 3ff 000 0",
                     bus.dir, bus.motion_y, bus.motion_x, bus.pend_valid);
        end
        start_right();
        for (int i = 0; i < 3; i++) tick(12'd2000, 12'd2500, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(12'd2000, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (got_vec() !== exp_vec() || bus.pend_valid !== (i < 15)) begin
                n_err++;
                $display("FAIL turn_timeout cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        n_vec++;
        if (bus.dir !== 2'd0 || bus.moving !== 1'b1) begin
            n_err++;
            $display("FAIL turn_expired dir=%0d mov=%b exp 0 1", bus.dir, bus.moving);
        end
    endtask

    task automatic test_reversal_stop();
        start_right();
        for (int i = 0; i < 3; i++) tick(12'd3000, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(12'd2000, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus.dir, bus.motion_x, bus.step_en} !== {2'd2, 10'h3FF, 1'b0}) begin
            n_err++;
            $display("FAIL reversal dir=%0d mx=%h st=%b exp 2 3ff 0", bus.dir, bus.motion_x, bus.step_en);
        end
        for (int i = 0; i < 5; i++) begin
            tick(12'd2000, 12'd1350, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if ({bus.moving, bus.step_en, bus.dir} !== {1'b0, 1'b0, 2'd2} || got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wall_stop cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_freeze_respawn();
        start_right();
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(12'd2000, 12'd2500, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if ({bus.moving, bus.step_en, bus.motion_x, bus.motion_y, bus.pend_valid, bus.has_moved}
                    !== {1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1} || got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL frozen cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(12'd100, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.moving !== 1'b1 || got_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL unfreeze_by_reset got=%h exp=%h", got_vec(), exp_vec());
        end
        start_right();
        for (int i = 0; i < 4; i++) tick(12'd2000, 12'd100, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(12'd2000, 12'd1350, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({bus.dir, bus.has_moved, bus.pend_valid, bus.moving} !== 5'b0 || got_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL respawn got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        int t_move, t_step;
        start_right();
        for (int i = 0; i < 3; i++) tick(12'd2000, 12'd2500, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.pend_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pend got=%b exp=1", bus.pend_valid);
        end
        tick(12'd2000, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (got_vec() !== 27'd0) begin
            n_err++;
            $display("FAIL mid_reset got=%h exp=%h", got_vec(), 27'd0);
        end
        t_move = -1; t_step = -1;
        for (int i = 0; i < 12; i++) begin
            tick(12'd100, 12'd1350, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.moving === 1'b1 && t_move < 0) t_move = i;
            if (bus.step_en === 1'b1 && t_step < 0) t_step = i;
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL mid_restart cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        n_vec++;
        if (t_move != DEBOUNCE || t_step != t_move + SPEED_DIV) begin
            n_err++;
            $display("FAIL mid_first_step move=%0d step=%0d exp %0d %0d",
                     t_move, t_step, DEBOUNCE, DEBOUNCE + SPEED_DIV);
        end
    endtask

    task automatic test_random();
        int pool [9] = '{0, 399, 400, 401, 1350, 2299, 2300, 2301, 4095};
        logic [11:0] xv, yv;
        logic [3:0]  wf;
        xv = 12'd2000; yv = 12'd1350; wf = 4'hF;
        tick(xv, yv, wf, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) begin
                xv = 12'(pool[$urandom_range(8)]);
                yv = 12'(pool[$urandom_range(8)]);
            end
            if ($urandom_range(5) == 0) wf = 4'($urandom);
            tick(xv, yv, wf, 1'($urandom_range(2) == 0), 1'($urandom_range(399) == 0),
                 1'($urandom_range(59) == 0), 1'($urandom_range(149) == 0));
            n_vec++;
            if (got_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.x_val = 12'd2000; bus.y_val = 12'd1350; bus.wall_free = 4'hF;
        bus.tile_aligned = 1'b0; bus.freeze = 1'b0; bus.respawn = 1'b0;
        model_clear();
        m_frozen = 0;
        #1;
        test_reset();
        test_idle_entry();
        test_glitch();
        test_turn_buffered();
        test_reversal_stop();
        test_freeze_respawn();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pacman_move_ctrl.md
Name: pacman_move_ctrl

Overview:
- Movement scheduler for the Pac-Man sprite. Converts the 12-bit joystick ADC readings into debounced direction requests and buffers each request until the turn is legal.
- Sequences the position datapath: outputs the current direction, the per-axis motion values and a step-enable pulse.
- Sits between the joystick ADC interface and the sprite position/wall-check logic. Replaces the ad hoc direction handling in the sprite module.

Parameters:
- LO_TH, 400: ADC value at or below which an axis reads "low".
- HI_TH, 2300: ADC value at or above which an axis reads "high".
- DEBOUNCE, 3: consecutive frames a request must be stable before it is accepted (1..15).
- SPEED_DIV, 2: frames per one-pixel step (1..15).
- HOLD_FRAMES, 16: lifetime of a buffered, not-yet-legal turn request (1..255).

Ports:
- frame_clk, in, 1: frame clock. The only clock.
- Reset, in, 1: synchronous, active-high reset.
- x_val, in, 12: joystick X ADC value.
- y_val, in, 12: joystick Y ADC value.
- wall_free, in, 4: bit i=1 means a step in direction i is open from the current position.
- tile_aligned, in, 1: sprite is on a tile centre; perpendicular turns are allowed only here.
- freeze, in, 1: death or victory; halts all motion.
- respawn, in, 1: life lost; return to spawn state.
- dir, out, 2: current direction. 0=right, 1=down, 2=left, 3=up.
- moving, out, 1: sprite is advancing.
- step_en, out, 1: one-cycle pulse; the position datapath adds motion_x/motion_y on this cycle.
- motion_x, out, 10: two's complement, +1, -1 (10'h3FF) or 0.
- motion_y, out, 10: two's complement, +1, -1 (10'h3FF) or 0.
- has_moved, out, 1: set by the first accepted move since reset/respawn.
- pend_valid, out, 1: a buffered turn is waiting.

Behaviour:
- All state is registered on posedge frame_clk.
- Priority order: Reset > freeze > respawn > normal operation.
- Reset values:
  - State is IDLE.
  - dir, moving, step_en, has_moved and pend_valid are all 0.
  - motion_x and motion_y are 0.
  - All counters are 0.
- Raw decode is combinational, priority highest first:
  - x_val<=LO_TH gives 0 (right).
  - x_val>=HI_TH gives 2 (left).
  - y_val>=HI_TH gives 3 (up).
  - y_val<=LO_TH gives 1 (down).
  - Anything else is neutral.
- Debounce:
  - Hold a candidate register and a 4-bit db_cnt.
  - If raw differs from the candidate or is neutral: load the candidate and set db_cnt=1 (0 if neutral).
  - If raw equals the candidate: db_cnt saturates at DEBOUNCE.
  - Accept exactly once, on the cycle db_cnt reaches DEBOUNCE. The request must go neutral or change before it can be re-accepted.
- Acceptance:
  - Sets pend_dir and pend_valid=1, and clears hold_cnt.
  - A newer acceptance overwrites the pending request.
  - Latency: raw stable from cycle 0 gives pend_valid=1 in cycle DEBOUNCE.
- Pending timeout: hold_cnt increments every cycle while pend_valid. pend_valid clears when hold_cnt==HOLD_FRAMES-1 and the pending turn was not applied that cycle.
- Turn application, evaluated every cycle in IDLE, MOVE and STOP while pend_valid:
  - If pend_dir==dir and state is MOVE: drop the pending request.
  - Reversal (pend_dir==dir^2) in MOVE: apply if wall_free[pend_dir], regardless of tile_aligned.
  - Otherwise: apply if wall_free[pend_dir] and (tile_aligned, or state is IDLE or STOP).
  - Applying sets dir=pend_dir, pend_valid=0, has_moved=1 and state=MOVE, and clears spd_cnt. The new dir is visible the cycle after pend_valid rises.
- States:
  - IDLE: spawn state, moving=0. Leaves only when a turn is applied.
  - MOVE: moving=1.
    - spd_cnt counts 0..SPEED_DIV-1 and wraps.
    - step_en=1 when spd_cnt==SPEED_DIV-1 and wall_free[dir].
    - If !wall_free[dir] and tile_aligned: go to STOP.
  - STOP: moving=0, step_en=0, dir is held. Leaves when a turn is applied.
  - FROZEN: entered from any state when freeze=1.
    - moving=0, step_en=0 and motion is 0.
    - dir and has_moved are held.
    - pend_valid is cleared and the debounce is held in reset.
    - Exit only via Reset.
- respawn (when not FROZEN):
  - Next state is IDLE.
  - dir=0, has_moved=0 and pend_valid=0.
  - All counters are cleared.
  - respawn overrides a same-cycle turn application.
- Motion outputs:
  - Registered, and consistent with dir/moving in the same cycle.
  - moving=0 gives both motions 0.
  - dir 0 gives x=+1; dir 2 gives x=-1; dir 1 gives y=+1; dir 3 gives y=-1.
  - The unused axis is always 0.
- Step timing: step_en is never asserted in the cycle dir changes. A step uses the motion values visible that same cycle.

Test Plan:
- Idle entry:
  - Stimulus: reset, then x_val=100, y_val=1350 held, wall_free=4'hF.
  - Response: pend_valid=1 at cycle 3; dir=0, moving=1, has_moved=1, motion_x=1 at cycle 4.
  - With SPEED_DIV=2, step_en pulses every 2nd cycle.
- Glitch rejection:
  - Stimulus: x_val=3000 for 2 cycles, then neutral.
  - Response: pend_valid never rises and dir is unchanged.
- Buffered perpendicular turn:
  - Stimulus: moving right, y_val=2500 accepted while tile_aligned=0; raise tile_aligned 5 cycles later.
  - Response: pend_valid=1 until alignment; dir=3 and motion_y=10'h3FF in the next cycle.
  - Repeat with 20 cycles unaligned: pend_valid clears at hold_cnt=15 and dir stays 0.
- Reversal and wall stop:
  - Stimulus: moving right, accept left with tile_aligned=0.
  - Response: dir=2 immediately after application.
  - Then clear wall_free[2] with tile_aligned=1: state goes to STOP, moving=0 and step_en stays 0.
- freeze/respawn priority:
  - Stimulus: assert freeze and respawn in the same cycle while moving.
  - Response: FROZEN; motion=0; joystick input is ignored; only Reset restores IDLE.
  - With respawn alone: dir=0, has_moved=0, pend_valid=0.
- Reset mid-operation:
  - Stimulus: assert Reset with pend_valid=1 and spd_cnt=1.
  - Response: in the next cycle all outputs are at their reset values; the first step after re-acceptance occurs SPEED_DIV cycles after the move starts.
